ldpc_mem_arbiter: RTL and testbench
===================================

Name: ldpc_mem_arbiter

Overview:
- Two-requester Avalon-MM arbiter in front of the shared 32-bit x 8192-word single-port on-chip RAM.
- Lets the LDPC decoder datapath (m0) and the host/Nios side (m1) share the RAM.
- Issues at most one access per clock, with round-robin arbitration and a bounded burst-hold so the decoder can stream.
- Returns read data one cycle after acceptance, matching the RAM's registered-address, unregistered-output timing.

Parameters:
- ADDR_W, 13, word address width (8192 words).
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_BURST, 8, max consecutive grants to one master while the other is waiting (range 1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m0_address / m1_address  in  ADDR_W  word address.
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes for writes.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_writedata / m1_writedata  in  DATA_W  write data.
- m0_waitrequest / m1_waitrequest  out  1  high = request not accepted this cycle.
- m0_readdata / m1_readdata  out  DATA_W  read data.
- m0_readdatavalid / m1_readdatavalid  out  1  readdata qualifier.
- mem_address  out  ADDR_W  to RAM.
- mem_byteenable  out  DATA_W/8  to RAM.
- mem_chipselect  out  1  to RAM.
- mem_write  out  1  to RAM.
- mem_writedata  out  DATA_W  to RAM.
- mem_clken  out  1  RAM clock enable.
- mem_readdata  in  DATA_W  from RAM, valid the cycle after the address is presented.

Behaviour:
- Request: reqX = mX_read | mX_write.
- Acceptance: accept when reqX & ~mX_waitrequest. mX_waitrequest = reqX & ~grantX (combinational). It is 0 when idle.
- Read and write asserted together on one master is a protocol violation; the write is performed and no readdatavalid is returned.
- State: owner register (OWN0/OWN1, reset OWN0) and run counter (8 bits, reset 0).
- Grant rule, evaluated each cycle:
  - Only one master requesting: grant it.
  - Both requesting and run < MAX_BURST: grant owner.
  - Both requesting and run >= MAX_BURST: grant the other master.
  - Neither requesting: no grant; owner is held; run is cleared to 0.
- Update on a grant:
  - Grant to the current owner: run <= run+1, saturating at 255.
  - Grant to the other master: owner <= granted master, run <= 1.
- RAM drive, combinational from the granted master:
  - mem_address, mem_byteenable and mem_writedata are muxed from the granted master.
  - mem_chipselect = any grant.
  - mem_write = granted master's write.
  - No grant: mem_chipselect=0, mem_write=0, address/data don't-care (drive 0).
- mem_clken is tied to 1.
- Read return:
  - A pipeline register rd_pend/rd_id captures an accepted read.
  - The next cycle: mX_readdatavalid=1 for rd_id, and mX_readdata = mem_readdata.
  - Back-to-back reads sustain 1 word/clock.
  - Readdata is gated to 0 when not valid.
- Write latency: a write is committed at the accepting edge; a read of the same address accepted the next cycle returns the new data.
- Reset (asynchronous, any time):
  - owner=OWN0, run=0, rd_pend=0, all readdatavalid=0.
  - A read accepted in the cycle of reset is discarded; the master must reissue.
- Reset values of combinational outputs with no requests: waitrequest=0, mem_chipselect=0, mem_write=0, mem_clken=1.

Optional Feature:
- Macro LDPC_MEM_ARB_STATS_EN.
- When defined, adds outputs stat_m0_grants (32), stat_m1_grants (32) and stat_conflicts (32), plus input stat_clear (1).
  - stat_mX_grants counts accepted accesses per master.
  - stat_conflicts counts cycles where both masters request.
  - All three counters wrap at 2^32.
  - reset or stat_clear zeroes them; stat_clear takes priority over counting in the same cycle.
- Without the macro, these ports and counters do not exist and arbitration behaviour is identical.

Test Plan:
- m0 write addr 0x0005 data 0xDEADBEEF be=0xF, then m0 read 0x0005 -> m0_readdatavalid one cycle after accept, readdata 0xDEADBEEF, m1 outputs quiet.
- m1 write be=0x3 data 0x0000ABCD over 0xFFFFFFFF at 0x1FFF, read back -> 0xFFFFABCD (address wrap edge, byte lanes).
- Both masters request reads continuously with MAX_BURST=8 -> grant pattern 8×m0, 8×m1, repeating; m1_waitrequest high on m0 cycles; no gaps on mem_chipselect.
- m1 idle, m0 issues 20 back-to-back reads -> all 20 accepted consecutively (no forced switch); 20 readdatavalid pulses in order.
- Reset asserted mid-burst the cycle after an m0 read accept -> m0_readdatavalid stays 0; after release owner=OWN0, first contended cycle grants m0.
- With LDPC_MEM_ARB_STATS_EN: 8 m0 + 8 m1 contended accesses -> stat_m0_grants=8, stat_m1_grants=8, stat_conflicts=16 (every cycle both request); stat_clear -> all 0.

Source files
------------

// File: rtl/ldpc_mem_arbiter_if.sv
// Bundle of the two requester Avalon-MM ports and the single-port RAM port.
// The slave modport is the arbiter's view, and the master modport is the requesters' and RAM's view.
// Pure signal container; no logic and no latency of its own.
interface ldpc_mem_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // requester 0 (decoder datapath)
  logic [ADDR_W-1:0] m0_address;
  logic [BE_W-1:0]   m0_byteenable;
  logic              m0_read;
  logic              m0_write;
  logic [DATA_W-1:0] m0_writedata;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;

  // requester 1 (host side)
  logic [ADDR_W-1:0] m1_address;
  logic [BE_W-1:0]   m1_byteenable;
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_writedata;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;

  // shared RAM
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
    output mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
    input  mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/ldpc_mem_arbiter.sv
// Purpose: round-robin arbiter with a burst-hold limit that lets two Avalon-MM masters share one single-port RAM.
// Latency: grant is combinational and the write commits at the accepting edge; read data returns one cycle after acceptance.
// Backpressure: a requesting master without the grant sees waitrequest high. With LDPC_MEM_ARB_STATS_EN defined, the block adds grant and conflict counters.
module ldpc_mem_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input logic                  clk,
  input logic                  reset,
  ldpc_mem_arbiter_if.slave    bus
`ifdef LDPC_MEM_ARB_STATS_EN
  ,
  input  logic                 stat_clear,
  output logic [31:0]          stat_m0_grants,
  output logic [31:0]          stat_m1_grants,
  output logic [31:0]          stat_conflicts
`endif
);

  localparam int         BE_W        = DATA_W / 8;
  localparam logic [7:0] MAX_BURST_8 = 8'(MAX_BURST);

  typedef enum logic {OWN0, OWN1} owner_t;

  owner_t     owner;
  logic [7:0] run;
  logic       rd_pend;
  logic       rd_id;

  logic req0, req1;
  logic grant0, grant1;
  logic rd_accept;

  assign req0 = bus.m0_read | bus.m0_write;
  assign req1 = bus.m1_read | bus.m1_write;

  // Grant selection: a lone requester always wins; under contention the owner keeps the RAM until its run reaches MAX_BURST.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0 && req1) begin
      if (run < MAX_BURST_8) begin
        grant0 = (owner == OWN0);
        grant1 = (owner == OWN1);
      end else begin
        grant0 = (owner == OWN1);
        grant1 = (owner == OWN0);
      end
    end else begin
      grant0 = req0;
      grant1 = req1;
    end
  end

  assign bus.m0_waitrequest = req0 & ~grant0;
  assign bus.m1_waitrequest = req1 & ~grant1;

  // A read that also has write asserted is treated as a write only, so it is never queued for return.
  assign rd_accept = (grant0 & bus.m0_read & ~bus.m0_write) |
                     (grant1 & bus.m1_read & ~bus.m1_write);

  // RAM port is driven from the granted master. It idles at zero so that unused cycles are quiet.
  always_comb begin
    bus.mem_address    = '0;
    bus.mem_byteenable = '0;
    bus.mem_writedata  = '0;
    bus.mem_write      = 1'b0;
    if (grant1) begin
      bus.mem_address    = bus.m1_address;
      bus.mem_byteenable = bus.m1_byteenable;
      bus.mem_writedata  = bus.m1_writedata;
      bus.mem_write      = bus.m1_write;
    end else if (grant0) begin
      bus.mem_address    = bus.m0_address;
      bus.mem_byteenable = bus.m0_byteenable;
      bus.mem_writedata  = bus.m0_writedata;
      bus.mem_write      = bus.m0_write;
    end
  end

  assign bus.mem_chipselect = grant0 | grant1;
  assign bus.mem_clken      = 1'b1;

  // Owner/run bookkeeping and the one-deep read-return pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner   <= OWN0;
      run     <= '0;
      rd_pend <= 1'b0;
      rd_id   <= 1'b0;
    end else begin
      rd_pend <= rd_accept;
      rd_id   <= grant1;
      if (grant0 || grant1) begin
        if (grant0 == (owner == OWN0)) begin
          if (run != 8'hFF) run <= run + 8'd1;
        end else begin
          owner <= grant0 ? OWN0 : OWN1;
          run   <= 8'd1;
        end
      end else begin
        run <= '0;
      end
    end
  end

  assign bus.m0_readdatavalid = rd_pend & ~rd_id;
  assign bus.m1_readdatavalid = rd_pend &  rd_id;
  assign bus.m0_readdata      = bus.m0_readdatavalid ? bus.mem_readdata : '0;
  assign bus.m1_readdata      = bus.m1_readdatavalid ? bus.mem_readdata : '0;

`ifdef LDPC_MEM_ARB_STATS_EN
  // Per-master accepted-access counters and a contention-cycle counter. A clear overrides counting in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_m0_grants <= '0;
      stat_m1_grants <= '0;
      stat_conflicts <= '0;
    end else if (stat_clear) begin
      stat_m0_grants <= '0;
      stat_m1_grants <= '0;
      stat_conflicts <= '0;
    end else begin
      if (grant0)        stat_m0_grants <= stat_m0_grants + 32'd1;
      if (grant1)        stat_m1_grants <= stat_m1_grants + 32'd1;
      if (req0 && req1)  stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ldpc_mem_arbiter.sv
// Directed bench for ldpc_mem_arbiter.
// The bench runs single-master traffic, contended round-robin traffic, a streaming run, reset during a pending read, and the optional stats counters.
// Includes a behavioural RAM with a registered address and an unregistered output.
module tb_ldpc_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ram_init = 1'b1;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  ldpc_mem_arbiter_if #(.ADDR_W(13), .DATA_W(32)) bus ();

`ifdef LDPC_MEM_ARB_STATS_EN
  logic        stat_clear = 1'b0;
  logic [31:0] stat_m0_grants, stat_m1_grants, stat_conflicts;
`endif

  ldpc_mem_arbiter #(.ADDR_W(13), .DATA_W(32), .MAX_BURST(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef LDPC_MEM_ARB_STATS_EN
    ,
    .stat_clear     (stat_clear),
    .stat_m0_grants (stat_m0_grants),
    .stat_m1_grants (stat_m1_grants),
    .stat_conflicts (stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: word i initialises to 0x10000000+i
  logic [31:0] ram [0:8191];
  logic [12:0] ram_aq = '0;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 8192; i++) ram[i] <= 32'h1000_0000 + 32'(i);
    end else if (bus.mem_chipselect && bus.mem_clken) begin
      if (bus.mem_write)
        for (int b = 0; b < 4; b++)
          if (bus.mem_byteenable[b]) ram[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
      ram_aq <= bus.mem_address;
    end
  end
  assign bus.mem_readdata = ram[ram_aq];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_reqs();
    bus.m0_read = 1'b0; bus.m0_write = 1'b0;
    bus.m1_read = 1'b0; bus.m1_write = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single uncontended access; returns just after the accepting edge.
  task automatic access(input int m, input logic wr, input logic [12:0] addr,
                        input logic [31:0] data, input logic [3:0] be);
    if (m == 0) begin
      bus.m0_address = addr; bus.m0_writedata = data; bus.m0_byteenable = be;
      bus.m0_write = wr; bus.m0_read = ~wr;
    end else begin
      bus.m1_address = addr; bus.m1_writedata = data; bus.m1_byteenable = be;
      bus.m1_write = wr; bus.m1_read = ~wr;
    end
    step();
    clear_reqs();
  endtask

  logic        exp_g0, prev_g0;
  logic [12:0] a0, a1, gaddr;
  logic [31:0] prev_data;

  initial begin
    clear_reqs();
    bus.m0_address = '0; bus.m0_byteenable = '0; bus.m0_writedata = '0;
    bus.m1_address = '0; bus.m1_byteenable = '0; bus.m1_writedata = '0;

    // reset state
    #2;
    chk("rst_m0_wait", bus.m0_waitrequest, 0);
    chk("rst_m1_wait", bus.m1_waitrequest, 0);
    chk("rst_cs",      bus.mem_chipselect, 0);
    chk("rst_mem_wr",  bus.mem_write, 0);
    chk("rst_clken",   bus.mem_clken, 1);
    chk("rst_m0_rdv",  bus.m0_readdatavalid, 0);
    chk("rst_m1_rdv",  bus.m1_readdatavalid, 0);
    step(); step();
    ram_init = 1'b0;
    reset = 1'b0;
    step();

    // m0 write then read back
    bus.m0_address = 13'h0005; bus.m0_writedata = 32'hDEADBEEF; bus.m0_byteenable = 4'hF;
    bus.m0_write = 1'b1;
    #2;
    chk("t1_wr_wait", bus.m0_waitrequest, 0);
    chk("t1_wr_cs",   bus.mem_chipselect, 1);
    chk("t1_wr_mw",   bus.mem_write, 1);
    chk("t1_wr_addr", 32'(bus.mem_address), 32'h5);
    chk("t1_wr_dat",  bus.mem_writedata, 32'hDEADBEEF);
    step();
    clear_reqs();
    access(0, 1'b0, 13'h0005, '0, 4'h0);
    chk("t1_rdv",     bus.m0_readdatavalid, 1);
    chk("t1_rdata",   bus.m0_readdata, 32'hDEADBEEF);
    chk("t1_m1_rdv",  bus.m1_readdatavalid, 0);
    chk("t1_m1_rdat", bus.m1_readdata, 0);
    step();
    chk("t1_rdv_off", bus.m0_readdatavalid, 0);
    chk("t1_rd_gate", bus.m0_readdata, 0);

    // m1 partial-byte write at the top address
    access(1, 1'b1, 13'h1FFF, 32'hFFFFFFFF, 4'hF);
    access(1, 1'b1, 13'h1FFF, 32'h0000ABCD, 4'h3);
    access(1, 1'b0, 13'h1FFF, '0, 4'h0);
    chk("t2_rdv",    bus.m1_readdatavalid, 1);
    chk("t2_rdata",  bus.m1_readdata, 32'hFFFFABCD);
    chk("t2_m0_rdv", bus.m0_readdatavalid, 0);
    step();

    // contended reads: 8 x m0, 8 x m1, repeating
    access(0, 1'b0, 13'h0000, '0, 4'h0);
    step();
    a0 = '0; a1 = '0; prev_g0 = 1'b0; prev_data = '0;
    for (int i = 0; i <= 32; i++) begin
      exp_g0 = ((i / 8) % 2) == 0;
      if (i < 32) begin
        bus.m0_read = 1'b1; bus.m0_address = 13'h100 + a0;
        bus.m1_read = 1'b1; bus.m1_address = 13'h200 + a1;
      end else begin
        clear_reqs();
      end
      #2;
      if (i < 32) begin
        chk($sformatf("t3_m0_wait_%0d", i), bus.m0_waitrequest, 32'(!exp_g0));
        chk($sformatf("t3_m1_wait_%0d", i), bus.m1_waitrequest, 32'(exp_g0));
        chk($sformatf("t3_cs_%0d", i), bus.mem_chipselect, 1);
      end
      if (i > 0) begin
        chk($sformatf("t3_m0_rdv_%0d", i), bus.m0_readdatavalid, 32'(prev_g0));
        chk($sformatf("t3_m1_rdv_%0d", i), bus.m1_readdatavalid, 32'(!prev_g0));
        if (prev_g0) chk($sformatf("t3_m0_dat_%0d", i), bus.m0_readdata, prev_data);
        else         chk($sformatf("t3_m1_dat_%0d", i), bus.m1_readdata, prev_data);
      end
      gaddr = exp_g0 ? 13'h100 + a0 : 13'h200 + a1;
      step();
      if (exp_g0) a0 = a0 + 13'd1; else a1 = a1 + 13'd1;
      prev_g0 = exp_g0;
      prev_data = 32'h1000_0000 + 32'(gaddr);
    end
    step();

    // m0 streams 20 reads alone, with no forced switch
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) begin
        bus.m0_read = 1'b1; bus.m0_address = 13'(13'h300 + i);
      end else begin
        clear_reqs();
      end
      #2;
      if (i < 20) chk($sformatf("t4_wait_%0d", i), bus.m0_waitrequest, 0);
      if (i > 0) begin
        chk($sformatf("t4_rdv_%0d", i), bus.m0_readdatavalid, 1);
        chk($sformatf("t4_dat_%0d", i), bus.m0_readdata, 32'h1000_0300 + 32'(i - 1));
      end
      step();
    end
    chk("t4_rdv_end", bus.m0_readdatavalid, 0);

    // reset right after an m0 read accept discards the return
    access(0, 1'b0, 13'h0010, '0, 4'h0);
    reset = 1'b1;
    #1;
    chk("t5_m0_rdv", bus.m0_readdatavalid, 0);
    chk("t5_m0_dat", bus.m0_readdata, 0);
    step();
    reset = 1'b0;
    // move ownership to m1, then reset again; m0 must win the first contended cycle
    access(1, 1'b0, 13'h0011, '0, 4'h0);
    reset = 1'b1;
    #1;
    chk("t5_m1_rdv", bus.m1_readdatavalid, 0);
    step();
    reset = 1'b0;
    bus.m0_read = 1'b1; bus.m0_address = 13'h0020;
    bus.m1_read = 1'b1; bus.m1_address = 13'h0021;
    #2;
    chk("t5_m0_wait", bus.m0_waitrequest, 0);
    chk("t5_m1_wait", bus.m1_waitrequest, 1);
    chk("t5_addr",    32'(bus.mem_address), 32'h20);
    step();
    clear_reqs();
    step();

`ifdef LDPC_MEM_ARB_STATS_EN
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.m0_read = 1'b1; bus.m0_address = 13'(i);
      bus.m1_read = 1'b1; bus.m1_address = 13'(i + 16);
      step();
    end
    clear_reqs();
    step();
    chk("t6_m0_grants",  stat_m0_grants, 32'd8);
    chk("t6_m1_grants",  stat_m1_grants, 32'd8);
    chk("t6_conflicts",  stat_conflicts, 32'd16);
    bus.m0_read = 1'b1; bus.m1_read = 1'b1;
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    clear_reqs();
    #1;
    chk("t6_clr_m0",   stat_m0_grants, 0);
    chk("t6_clr_m1",   stat_m1_grants, 0);
    chk("t6_clr_conf", stat_conflicts, 0);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
